// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control slice: FSM states, opcodes,
// funct fields, ALU control codes and the decoded instruction class.
package riscv_pkg;

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_MEM       = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_TRAP      = 3'd5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [2:0] {
    K_NOP    = 3'd0,
    K_ALU    = 3'd1,
    K_LOAD   = 3'd2,
    K_STORE  = 3'd3,
    K_BEQ    = 3'd4,
    K_BNE    = 3'd5
  } kind_e;

  // Logical-op funct3 to ALU code; arithmetic add is the fallback.
  function automatic logic [2:0] f3_to_alu(input logic [2:0] f3);
    logic [2:0] r;
    case (f3)
      F3_XOR:  r = ALU_XOR;
      F3_OR:   r = ALU_OR;
      F3_AND:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_imm_decode.sv
// Combinational field, class and sign-extended immediate decode of an RV32I word.
module riscv_imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output kind_e           kind_o,
  output logic [2:0]      alu_op_o,
  output logic            b_imm_o
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;

  assign opcode_s = ir_i[6:0];
  assign funct3_s = ir_i[14:12];
  assign funct7_s = ir_i[31:25];
  assign rs1_o    = ir_i[19:15];
  assign rs2_o    = ir_i[24:20];
  assign rd_o     = ir_i[11:7];

  // Immediate format follows the opcode; everything else reads as I-type.
  always_comb begin
    imm_o = {{(XLEN-12){ir_i[31]}}, ir_i[31:20]};
    case (opcode_s)
      OPC_STORE:  imm_o = {{(XLEN-12){ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
      OPC_BRANCH: imm_o = {{(XLEN-13){ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
      default:    imm_o = {{(XLEN-12){ir_i[31]}}, ir_i[31:20]};
    endcase
  end

  // Unsupported encodings fall through as K_NOP.
  always_comb begin
    kind_o   = K_NOP;
    alu_op_o = ALU_ADD;
    b_imm_o  = 1'b0;
    case (opcode_s)
      OPC_LOAD: begin
        if (funct3_s == F3_LW) begin
          kind_o  = K_LOAD;
          b_imm_o = 1'b1;
        end else begin
          kind_o = K_NOP;
        end
      end
      OPC_STORE: begin
        if (funct3_s == F3_LW) begin
          kind_o  = K_STORE;
          b_imm_o = 1'b1;
        end else begin
          kind_o = K_NOP;
        end
      end
      OPC_OPIMM: begin
        case (funct3_s)
          F3_ADD, F3_XOR, F3_OR, F3_AND: begin
            kind_o   = K_ALU;
            alu_op_o = f3_to_alu(funct3_s);
            b_imm_o  = 1'b1;
          end
          default: kind_o = K_NOP;
        endcase
      end
      OPC_OP: begin
        if (funct7_s == F7_BASE && (funct3_s == F3_ADD || funct3_s == F3_XOR ||
                                    funct3_s == F3_OR  || funct3_s == F3_AND)) begin
          kind_o   = K_ALU;
          alu_op_o = f3_to_alu(funct3_s);
        end else if (funct7_s == F7_SUB && funct3_s == F3_ADD) begin
          kind_o   = K_ALU;
          alu_op_o = ALU_SUB;
        end else begin
          kind_o = K_NOP;
        end
      end
      OPC_BRANCH: begin
        alu_op_o = ALU_SUB;
        case (funct3_s)
          F3_BEQ:  kind_o = K_BEQ;
          F3_BNE:  kind_o = K_BNE;
          default: begin
            kind_o   = K_NOP;
            alu_op_o = ALU_ADD;
          end
        endcase
      end
      default: kind_o = K_NOP;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I control FSM with fetch/memory handshakes.
// Optional RISCV_CTRL_ILLEGAL_TRAP_EN adds a sticky trap on illegal words and memory timeout.
module riscv_multicycle_control
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            mem_req,
  input  logic            mem_ack,
  input  logic            branch_taken,
  output logic [2:0]      alu_ctrl,
  output logic            alu_b_source,
  output logic            reg_write_enable,
  output logic            reg_write_source,
  output logic            data_mem_write_enable,
  output logic            pc_write,
  output logic            pc_branch,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] immediate,
  output logic            busy,
  output logic            trap
);

  logic [2:0]      state_q, state_d;
  logic [31:0]     ir_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] imm_q;
  kind_e           kind_q;
  logic [2:0]      alu_q;
  logic            bimm_q;

  logic [4:0]      dec_rs1_s, dec_rs2_s, dec_rd_s;
  logic [XLEN-1:0] dec_imm_s;
  kind_e           dec_kind_s;
  logic [2:0]      dec_alu_s;
  logic            dec_bimm_s;
  logic            take_s;
  logic            tmo_hit_s;

  riscv_imm_decode #(.XLEN(XLEN)) u_dec (
    .ir_i     (ir_q),
    .rs1_o    (dec_rs1_s),
    .rs2_o    (dec_rs2_s),
    .rd_o     (dec_rd_s),
    .imm_o    (dec_imm_s),
    .kind_o   (dec_kind_s),
    .alu_op_o (dec_alu_s),
    .b_imm_o  (dec_bimm_s)
  );

`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] tmo_q;

  // Counts consecutive un-acked MEM cycles; cleared outside MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == ST_MEM && !mem_ack) begin
      tmo_q <= tmo_q + TW'(1);
    end else begin
      tmo_q <= '0;
    end
  end

  assign tmo_hit_s = (tmo_q == TW'(MEM_TIMEOUT - 1));
  assign trap      = (state_q == ST_TRAP);
`else
  assign tmo_hit_s = 1'b0;
  assign trap      = 1'b0;
`endif

  // State, instruction register and decoded fields (held until the next accept).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= 32'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      imm_q   <= '0;
      kind_q  <= K_NOP;
      alu_q   <= ALU_ADD;
      bimm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && instr_valid) begin
        ir_q <= instr;
      end
      if (state_q == ST_DECODE) begin
        rs1_q  <= dec_rs1_s;
        rs2_q  <= dec_rs2_s;
        rd_q   <= dec_rd_s;
        imm_q  <= dec_imm_s;
        kind_q <= dec_kind_s;
        alu_q  <= dec_alu_s;
        bimm_q <= dec_bimm_s;
      end
    end
  end

  // Next-state sequencing per instruction class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) state_d = ST_DECODE;
        else             state_d = ST_FETCH;
      end
      ST_DECODE: begin
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
        if (dec_kind_s == K_NOP) state_d = ST_TRAP;
        else                     state_d = ST_EXECUTE;
`else
        state_d = ST_EXECUTE;
`endif
      end
      ST_EXECUTE: begin
        case (kind_q)
          K_ALU:           state_d = ST_WRITEBACK;
          K_LOAD, K_STORE: state_d = ST_MEM;
          default:         state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_ack)        state_d = (kind_q == K_LOAD) ? ST_WRITEBACK : ST_FETCH;
        else if (tmo_hit_s) state_d = ST_TRAP;
        else                state_d = ST_MEM;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_FETCH;
    endcase
  end

  assign take_s = (kind_q == K_BEQ && branch_taken) || (kind_q == K_BNE && !branch_taken);

  // Strobes decoded from the registered state and instruction class.
  always_comb begin
    instr_ready           = (state_q == ST_FETCH);
    busy                  = (state_q != ST_FETCH);
    mem_req               = (state_q == ST_MEM);
    data_mem_write_enable = (state_q == ST_MEM) && (kind_q == K_STORE);
    reg_write_enable      = (state_q == ST_WRITEBACK) && (rd_q != 5'd0);
    reg_write_source      = (state_q == ST_WRITEBACK) && (kind_q == K_LOAD);
    alu_ctrl              = (state_q == ST_EXECUTE) ? alu_q : ALU_ADD;
    alu_b_source          = (state_q == ST_EXECUTE) && bimm_q;
    pc_write              = 1'b0;
    pc_branch             = 1'b0;
    case (state_q)
      ST_EXECUTE: begin
        if (kind_q == K_BEQ || kind_q == K_BNE) begin
          pc_branch = take_s;
          pc_write  = !take_s;
        end else if (kind_q == K_NOP) begin
          pc_write = 1'b1;
        end else begin
          pc_write = 1'b0;
        end
      end
      ST_MEM:       pc_write = mem_ack && (kind_q == K_STORE);
      ST_WRITEBACK: pc_write = 1'b1;
      default:      pc_write = 1'b0;
    endcase
  end

  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign immediate = imm_q;

endmodule
